// File: rtl/fpu_encoder_if.sv
// Handshake and data bundle between an FPU arithmetic stage, the FP32 packer
// and the writeback consumer.
interface fpu_encoder_if;
   logic        in_valid_i;
   logic        in_ready_o;
   logic        sign_i;
   logic [9:0]  exp_i;
   logic [27:0] sig_i;
   logic        sticky_i;
   logic [2:0]  rm_i;
   logic        nan_i;
   logic        inf_i;
   logic        zero_i;
   logic        invalid_i;
   logic        divzero_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic [4:0]  fflags_o;

   modport master (
      output in_valid_i, sign_i, exp_i, sig_i, sticky_i, rm_i,
             nan_i, inf_i, zero_i, invalid_i, divzero_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, fflags_o
   );

   modport slave (
      input  in_valid_i, sign_i, exp_i, sig_i, sticky_i, rm_i,
             nan_i, inf_i, zero_i, invalid_i, divzero_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, fflags_o
   );
endinterface

// File: rtl/fpu_encoder.sv
// Multi-cycle FP32 result packer: iterative normalize, RISC-V rounding, IEEE-754
// packing with fflags, valid/ready on both sides and one operation in flight.
module fpu_encoder (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         flush_i,
   fpu_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

   localparam logic signed [11:0] EXP_ONE      = 12'sd1;
   localparam logic signed [11:0] EXP_COLLAPSE = -12'sd30;
   localparam logic signed [11:0] EXP_OVF      = 12'sd255;

   state_e             state_q;
   logic               sign_q;
   logic               nv_q;
   logic               dz_q;
   logic [2:0]         rm_q;
   logic signed [11:0] exp_q;
   logic signed [11:0] exp_d;
   logic [27:0]        sig_q;
   logic [27:0]        sig_d;
   logic [31:0]        result_q;
   logic [31:0]        round_res_d;
   logic [4:0]         fflags_q;
   logic [4:0]         round_flags_d;
   logic               accept;
   logic               special;
   logic               norm_zero;
   logic               norm_done;

   function automatic logic [31:0] special_pack(input logic s, input logic nan, input logic inf);
      logic [31:0] r;
      r = {s, 31'h0};
      if (nan)      r = 32'h7FC0_0000;
      else if (inf) r = {s, 8'hFF, 23'h0};
      return r;
   endfunction

   // Returns {fflags, result}; sg[27] is already clear, so the rounded
   // mantissa carries at most into m[24].
   function automatic logic [36:0] round_pack(input logic s, input logic signed [11:0] e,
                                              input logic [27:0] sg, input logic [2:0] rm,
                                              input logic nv, input logic dz);
      logic               g;
      logic               rest;
      logic               nx;
      logic               inc;
      logic [24:0]        m;
      logic signed [11:0] e_r;
      logic [7:0]         fld;
      logic [31:0]        r;
      logic [4:0]         f;
      g    = sg[2];
      rest = sg[1] | sg[0];
      nx   = g | rest;
      case (rm)
         3'b001:  inc = 1'b0;
         3'b010:  inc = s & nx;
         3'b011:  inc = ~s & nx;
         3'b100:  inc = g;
         default: inc = g & (rest | sg[3]);
      endcase
      m   = sg[27:3] + {24'd0, inc};
      e_r = e;
      if (m[24]) begin
         m   = m >> 1;
         e_r = e + EXP_ONE;
      end
      if (e_r >= EXP_OVF) begin
         case (rm)
            3'b001:  r = {s, 31'h7F7F_FFFF};
            3'b010:  r = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
            3'b011:  r = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
            default: r = {s, 31'h7F80_0000};
         endcase
         f = {nv, dz, 3'b101};
      end else begin
         fld = m[23] ? e_r[7:0] : 8'd0;
         r   = {s, fld, m[22:0]};
         f   = {nv, dz, 1'b0, nx & (fld == 8'd0), nx};
      end
      return {f, r};
   endfunction

   assign accept  = bus.in_valid_i & (state_q == IDLE) & ~flush_i;
   assign special = bus.nan_i | bus.inf_i | bus.zero_i;

   // One normalize action per NORM cycle, first matching rule wins.
   always_comb begin
      sig_d     = sig_q;
      exp_d     = exp_q;
      norm_zero = 1'b0;
      norm_done = 1'b0;
      if (sig_q == 28'd0) begin
         norm_zero = 1'b1;
      end else if (exp_q < EXP_COLLAPSE) begin
         sig_d = {27'd0, |sig_q};
         exp_d = EXP_ONE;
      end else if (sig_q[27] || (exp_q < EXP_ONE)) begin
         sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
         exp_d = exp_q + EXP_ONE;
      end else if (!sig_q[26] && (exp_q > EXP_ONE)) begin
         sig_d = {sig_q[26:0], 1'b0};
         exp_d = exp_q - EXP_ONE;
      end else begin
         norm_done = 1'b1;
      end
   end

   assign {round_flags_d, round_res_d} = round_pack(sign_q, exp_q, sig_q, rm_q, nv_q, dz_q);

   always_ff @(posedge clk_i) begin
      if (accept) begin
         sign_q <= bus.sign_i;
         nv_q   <= bus.invalid_i;
         dz_q   <= bus.divzero_i;
         rm_q   <= bus.rm_i;
         exp_q  <= {{2{bus.exp_i[9]}}, bus.exp_i};
         sig_q  <= {bus.sig_i[27:1], bus.sig_i[0] | bus.sticky_i};
      end else if (state_q == NORM) begin
         exp_q <= exp_d;
         sig_q <= sig_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         result_q <= 32'h0;
         fflags_q <= 5'h0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && special) begin
                  result_q <= special_pack(bus.sign_i, bus.nan_i, bus.inf_i);
                  fflags_q <= {bus.invalid_i, bus.divzero_i, 3'b000};
                  state_q  <= DONE;
               end else if (accept) begin
                  state_q <= NORM;
               end
            end
            NORM: begin
               if (norm_zero) begin
                  result_q <= {sign_q, 31'h0};
                  fflags_q <= 5'h0;
                  state_q  <= DONE;
               end else if (norm_done) begin
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               result_q <= round_res_d;
               fflags_q <= round_flags_d;
               state_q  <= DONE;
            end
            default: begin
               if (bus.out_ready_i) state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == DONE);
   assign bus.result_o    = result_q;
   assign bus.fflags_o    = fflags_q;
endmodule

// File: tb/tb_fpu_encoder.sv
// Directed bench for fpu_encoder: value-level FP32 reference model, per-cycle
// output comparison, and literal expectations for each vector.
module tb_fpu_encoder;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   fpu_encoder_if bus ();

   fpu_encoder dut (
      .clk_i   (clk),
      .reset_i (reset_n),
      .flush_i (flush),
      .bus     (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [36:0] expq[$];
   bit          busy = 1'b0;
   bit          seen_valid = 1'b0;
   logic [31:0] seen_res;
   logic [4:0]  seen_flg;
   int          handshakes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference: locate the value's leading one, pick the result quantum
   // (2^-149 for subnormals), then round the exact quotient.
   task automatic model(input bit s, input logic [9:0] ex, input logic [27:0] sg, input bit st,
                        input logic [2:0] rm, input bit nan, input bit inf, input bit zero,
                        input bit inv, input bit dz, output logic [31:0] r, output logic [4:0] f);
      longint unsigned sv;
      longint unsigned q;
      int  e, p, eb, k, fld;
      bit  g, rest, nx, inc, sub;
      f = {inv, dz, 3'b000};
      sv = 64'(sg) | 64'(st);
      if (nan)       r = 32'h7FC0_0000;
      else if (inf)  r = {s, 8'hFF, 23'h0};
      else if (zero) r = {s, 31'h0};
      else if (sv == 0) begin
         r = {s, 31'h0};
         f = 5'h0;
      end else begin
         e = int'($signed(ex));
         p = 0;
         for (int i = 0; i < 28; i++) if (sv[i]) p = i;
         eb  = p + e - 26;
         sub = (eb < 1);
         k   = sub ? (4 - e) : (p - 23);
         if (k <= 0) begin
            q = sv << (-k); g = 1'b0; rest = 1'b0;
         end else if (k >= 40) begin
            q = 0; g = 1'b0; rest = 1'b1;
         end else begin
            q    = sv >> k;
            g    = ((sv >> (k - 1)) & 64'd1) != 0;
            rest = (sv & ((64'd1 << (k - 1)) - 64'd1)) != 0;
         end
         nx = g | rest;
         case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s & nx;
            3'd3:    inc = !s & nx;
            3'd4:    inc = g;
            default: inc = g & (rest | q[0]);
         endcase
         q = q + 64'(inc);
         if (!sub && q == 64'h100_0000) begin
            q = q >> 1;
            eb++;
         end
         fld = sub ? ((q >= 64'h80_0000) ? 1 : 0) : eb;
         if (fld >= 255) begin
            case (rm)
               3'd1:    r = {s, 31'h7F7F_FFFF};
               3'd2:    r = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
               3'd3:    r = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
               default: r = {s, 31'h7F80_0000};
            endcase
            f = {inv, dz, 3'b101};
         end else begin
            r = {s, fld[7:0], q[22:0]};
            f = {inv, dz, 1'b0, nx && (fld == 0), nx};
         end
      end
   endtask

   // Per-cycle compare at the falling edge, then predict the coming rising edge.
   task automatic monitor();
      logic [31:0] mr;
      logic [4:0]  mf;
      chk("in_ready", 64'(bus.in_ready_o), 64'(!busy));
      if (expq.size() == 0) chk("valid_without_op", 64'(bus.out_valid_o), 64'd0);
      else if (bus.out_valid_o) begin
         chk("result_vs_model", 64'({bus.fflags_o, bus.result_o}), 64'(expq[0]));
         if (!seen_valid) begin
            seen_valid = 1'b1;
            seen_res   = bus.result_o;
            seen_flg   = bus.fflags_o;
         end
      end
      if (flush) begin
         expq.delete();
         busy = 1'b0;
      end else if (busy && bus.out_valid_o && bus.out_ready_i) begin
         void'(expq.pop_front());
         busy = 1'b0;
         handshakes++;
      end else if (!busy && bus.in_valid_i) begin
         model(bus.sign_i, bus.exp_i, bus.sig_i, bus.sticky_i, bus.rm_i, bus.nan_i, bus.inf_i,
               bus.zero_i, bus.invalid_i, bus.divzero_i, mr, mf);
         expq.push_back({mf, mr});
         busy = 1'b1;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s, input logic [9:0] e, input logic [27:0] sg, input bit st,
                        input logic [2:0] rm, input bit nan, input bit inf, input bit zero,
                        input bit inv, input bit dz);
      bus.sign_i = s;     bus.exp_i = e;       bus.sig_i = sg;      bus.sticky_i = st;
      bus.rm_i = rm;      bus.nan_i = nan;     bus.inf_i = inf;     bus.zero_i = zero;
      bus.invalid_i = inv; bus.divzero_i = dz;
   endtask

   task automatic op(input string name, input bit s, input logic [9:0] e, input logic [27:0] sg,
                     input bit st, input logic [2:0] rm, input bit nan, input bit inf,
                     input bit zero, input bit inv, input bit dz, input logic [31:0] lit_r,
                     input logic [4:0] lit_f, input int lit_lat, input int hold);
      logic [31:0] mr;
      logic [4:0]  mf;
      int n, hs0;
      model(s, e, sg, st, rm, nan, inf, zero, inv, dz, mr, mf);
      chk({name, "_model"}, 64'({mf, mr}), 64'({lit_f, lit_r}));
      drive(s, e, sg, st, rm, nan, inf, zero, inv, dz);
      bus.out_ready_i = (hold == 0);
      bus.in_valid_i  = 1'b1;
      seen_valid = 1'b0;
      hs0 = handshakes;
      cyc();
      bus.in_valid_i = 1'b0;
      n = 0;
      while (!seen_valid && n < 80) begin
         n++;
         cyc();
      end
      chk({name, "_valid_seen"}, 64'(seen_valid), 64'd1);
      if (seen_valid) begin
         chk({name, "_result"}, 64'({seen_flg, seen_res}), 64'({lit_f, lit_r}));
         chk({name, "_latency"}, 64'(n), 64'(lit_lat));
      end
      if (hold > 0) begin
         repeat (hold - 1) cyc();
         bus.out_ready_i = 1'b1;
         cyc();
      end
      chk({name, "_handshakes"}, 64'(handshakes - hs0), 64'd1);
      cyc();
   endtask

   initial begin
      int nv;
      drive(0, 10'd0, 28'd0, 0, 3'd0, 0, 0, 0, 0, 0);
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      #12;
      chk("reset_in_ready",  64'(bus.in_ready_o),  64'd1);
      chk("reset_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("reset_result",    64'(bus.result_o),    64'd0);
      chk("reset_fflags",    64'(bus.fflags_o),    64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      op("one",        0, 10'd127, 28'h400_0000, 0, 3'd0, 0,0,0,0,0, 32'h3F80_0000, 5'h00, 3, 0);
      op("rne_carry",  0, 10'd127, 28'h7FF_FFFC, 0, 3'd0, 0,0,0,0,0, 32'h4000_0000, 5'h01, 3, 0);
      op("rne_tie",    0, 10'd127, 28'h400_0004, 0, 3'd0, 0,0,0,0,0, 32'h3F80_0000, 5'h01, 3, 0);
      op("rmm_tie",    0, 10'd127, 28'h400_0004, 0, 3'd4, 0,0,0,0,0, 32'h3F80_0001, 5'h01, 3, 0);
      op("ovf_rtz",    0, 10'd255, 28'h400_0000, 0, 3'd1, 0,0,0,0,0, 32'h7F7F_FFFF, 5'h05, 3, 0);
      op("ovf_rne",    0, 10'd255, 28'h400_0000, 0, 3'd0, 0,0,0,0,0, 32'h7F80_0000, 5'h05, 3, 0);
      op("ovf_rup_n",  1, 10'd255, 28'h400_0000, 0, 3'd3, 0,0,0,0,0, 32'hFF7F_FFFF, 5'h05, 3, 0);
      op("ovf_rdn_p",  0, 10'd255, 28'h400_0000, 0, 3'd2, 0,0,0,0,0, 32'h7F7F_FFFF, 5'h05, 3, 0);
      op("sub_rne",    0, 10'h3FF, 28'h400_0000, 0, 3'd0, 0,0,0,0,0, 32'h0020_0000, 5'h00, 5, 0);
      op("sub_stk",    0, 10'h3FF, 28'h400_0000, 1, 3'd1, 0,0,0,0,0, 32'h0020_0000, 5'h03, 5, 0);
      op("nan_hold",   0, 10'd0,   28'd0,        0, 3'd0, 1,0,0,1,0, 32'h7FC0_0000, 5'h10, 1, 5);
      op("inf_neg",    1, 10'd0,   28'd0,        0, 3'd0, 0,1,0,0,1, 32'hFF80_0000, 5'h08, 1, 0);
      op("spec_prio",  1, 10'd0,   28'd0,        0, 3'd0, 1,1,1,0,0, 32'h7FC0_0000, 5'h00, 1, 0);
      op("spec_zero",  1, 10'd0,   28'd0,        0, 3'd0, 0,0,1,0,0, 32'h8000_0000, 5'h00, 1, 0);
      op("exact_zero", 1, 10'd5,   28'd0,        0, 3'd0, 0,0,0,0,0, 32'h8000_0000, 5'h00, 2, 0);
      op("carry_in",   0, 10'd127, 28'h800_0000, 0, 3'd0, 0,0,0,0,0, 32'h4000_0000, 5'h00, 4, 0);
      op("left20",     0, 10'd127, 28'h000_0040, 0, 3'd0, 0,0,0,0,0, 32'h3580_0000, 5'h00, 23, 0);
      op("collapse",   0, 10'h200, 28'h400_0000, 0, 3'd3, 0,0,0,0,0, 32'h0000_0001, 5'h03, 4, 0);
      op("rdn_neg",    1, 10'd127, 28'h400_0001, 0, 3'd2, 0,0,0,0,0, 32'hBF80_0001, 5'h01, 3, 0);
      op("rup_neg",    1, 10'd127, 28'h400_0001, 0, 3'd3, 0,0,0,0,0, 32'hBF80_0000, 5'h01, 3, 0);
      op("rm7_rne",    0, 10'd127, 28'h400_0006, 0, 3'd7, 0,0,0,0,0, 32'h3F80_0001, 5'h01, 3, 0);
      op("round_ovf",  0, 10'd254, 28'h7FF_FFFC, 0, 3'd0, 0,0,0,0,0, 32'h7F80_0000, 5'h05, 3, 0);
      op("min_normal", 0, 10'd1,   28'h3FF_FFFC, 0, 3'd0, 0,0,0,0,0, 32'h0080_0000, 5'h01, 3, 0);

      // Flush in the middle of a long normalize run.
      drive(0, 10'd127, 28'h000_0040, 0, 3'd0, 0, 0, 0, 0, 0);
      bus.in_valid_i = 1'b1;
      cyc();
      bus.in_valid_i = 1'b0;
      repeat (5) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
      nv = 0;
      repeat (30) begin
         cyc();
         if (bus.out_valid_o) nv++;
      end
      chk("flush_no_valid", 64'(nv), 64'd0);

      // Flush wins over a simultaneous accept.
      bus.in_valid_i = 1'b1;
      flush = 1'b1;
      cyc();
      bus.in_valid_i = 1'b0;
      flush = 1'b0;
      chk("flush_drop_ready", 64'(bus.in_ready_o), 64'd1);
      nv = 0;
      repeat (5) begin
         cyc();
         if (bus.out_valid_o) nv++;
      end
      chk("flush_drop_no_valid", 64'(nv), 64'd0);

      // Asynchronous reset while in ROUND.
      drive(0, 10'd127, 28'h400_0000, 0, 3'd0, 0, 0, 0, 0, 0);
      bus.in_valid_i = 1'b1;
      cyc();
      bus.in_valid_i = 1'b0;
      cyc();
      #2;
      reset_n = 1'b0;
      #1;
      expq.delete();
      busy = 1'b0;
      chk("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("arst_result",    64'(bus.result_o),    64'd0);
      chk("arst_fflags",    64'(bus.fflags_o),    64'd0);
      chk("arst_in_ready",  64'(bus.in_ready_o),  64'd1);
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc();
      op("after_rst",  0, 10'd128, 28'h600_0000, 0, 3'd0, 0,0,0,0,0, 32'h4040_0000, 5'h00, 3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/fpu_encoder.md
# fpu_encoder

Multi-cycle FP32 result packer for the FPU arithmetic path; the inverse of operand unpacking. It accepts an unpacked sign, a signed biased exponent and an extended significand with guard/round/sticky bits, or special-value flags. It normalizes iteratively, rounds per the RISC-V rounding mode, and emits a packed IEEE-754 single with fflags. Valid/ready handshakes sit on both sides so it can follow any arithmetic unit and be back-pressured by the writeback stage.

## Interface
- No parameters.
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort; returns to IDLE.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  high only in IDLE.
- sign_i  in  1  result sign.
- exp_i  in  10  two's-complement biased exponent.
- sig_i  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky. Value = sig/2^26 · 2^(exp−127).
- sticky_i  in  1  extra sticky, ORed into sig_i[0].
- rm_i  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- nan_i, inf_i, zero_i  in  1 each  special result; priority nan > inf > zero.
- invalid_i, divzero_i  in  1 each  passed to NV/DZ.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- result_o  out  32  packed FP32.
- fflags_o  out  5  {NV, DZ, OF, UF, NX}.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- Reset values: state IDLE, so in_ready_o=1, out_valid_o=0, result_o=0, fflags_o=0.
- **IDLE**
  - An accept (in_valid_i & in_ready_o) registers all inputs.
  - If any special flag is set, go to DONE.
  - Otherwise go to NORM.
- **Specials**
  - NaN packs to 0x7FC00000 (canonical, sign ignored).
  - Inf packs to {sign,0xFF,0}.
  - Zero packs to {sign,0}.
  - NV=invalid_i, DZ=divzero_i; OF/UF/NX=0.
- **NORM**: one action per cycle, first match wins.
  1. If sig==0, go to DONE with {sign,0} and flags 0.
  2. If exp < −30, collapse: sig={27'b0, |sig}, exp=1.
  3. If sig[27]: shift right 1 with bit 0 sticky-ORed; exp+1.
  4. If exp<1: shift right 1 with sticky; exp+1.
  5. If !sig[26] and exp>1: shift left 1; exp−1.
  6. Otherwise go to ROUND.
- **ROUND** (one cycle), using lsb=sig[3], g=sig[2], rest=sig[1]|sig[0]:
  - NX = g|rest.
  - Increment: RNE g&(rest|lsb); RTZ 0; RDN sign&NX; RUP !sign&NX; RMM g.
  - m = sig[27:3] + inc. If m[24] is set, shift m right 1 and exp+1.
  - Exponent field = m[23] ? exp : 0, so a subnormal that rounds up to the hidden bit becomes exponent 1 naturally.
- **Overflow** (exp ≥ 255 after rounding): OF=NX=1. The result depends on rm:
  - RNE/RMM: ±Inf.
  - RTZ: ±0x7F7FFFFF.
  - RDN: +max or −Inf.
  - RUP: +Inf or −max.
- **Underflow**: UF = NX & (final exponent field == 0). A result that rounds up to min-normal does not raise UF.
- **DONE**
  - out_valid_o=1; result_o and fflags_o are held stable.
  - On out_valid_o & out_ready_i, go to IDLE.
- **flush_i**
  - Forces IDLE next edge from any state and clears out_valid_o.
  - flush_i has priority over an accept in the same cycle; the accept is dropped.
- reset_i low at any time clears state immediately, including mid-NORM or DONE.

## Timing
- Accept at edge E.
- Already-normalized finite input: NORM occupies E+1, ROUND E+2, out_valid_o from E+3.
- Each extra normalize shift adds one cycle.
- Worst case is bounded by the collapse rule to ≤ 34 NORM cycles.
- Specials and exact zero: out_valid_o from E+1 (specials) or one cycle after detection (zero).
- Throughput: at most one operation in flight. in_ready_o is low from E+1 until the cycle after the DONE handshake.
- Back-to-back: the DONE handshake at edge H returns to IDLE; the next accept is possible at H+1.
- result_o and fflags_o change only when entering DONE or on reset.

## Test plan
- exp=127, sig=1<<26, RNE -> 0x3F800000, fflags 0x00, out_valid_o first high 3 cycles after accept.
- exp=127, sig={0,1,23'h7FFFFF,3'b100}, RNE -> 0x40000000, NX (0x01). sig={0,1,23'h0,3'b100}: RNE -> 0x3F800000 NX; RMM -> 0x3F800001 NX.
- exp=255, sig=1<<26, with sign 0:
  - RTZ -> 0x7F7FFFFF, fflags 0x05.
  - RNE -> 0x7F800000, fflags 0x05.
  - sign=1, RUP -> 0xFF7FFFFF.
- exp=10'h3FF (−1), sig=1<<26:
  - RNE -> 0x00200000, fflags 0x00.
  - sticky_i=1, RTZ -> 0x00200000, fflags 0x03.
- nan_i=invalid_i=1 -> 0x7FC00000, fflags 0x10 at E+1. Hold out_ready_i low 5 cycles -> result stable, in_ready_o=0, single handshake on release.
- exp=127, sig=1<<6 (20 left shifts): flush_i mid-NORM -> out_valid_o never rises, in_ready_o=1 next cycle. Repeat with reset_i low during ROUND -> outputs zero immediately.
